plru_req_driver: RTL and testbench

PLRU_REQ_DRIVER -- requirements
Module: plru_req_driver

---
 rtl/plru_req_driver_pkg.sv | 21 ++
 rtl/plru_ack_sync.sv | 28 ++
 rtl/plru_req_driver.sv | 215 +++++++++++++++++++++
 tb/tb_plru_req_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/plru_req_driver_pkg.sv
// Shared types and defaults for the PLRU request driver: FSM states, parameter
// defaults, lane count and the saturating counter increment.
package plru_req_driver_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int LANE_NUM        = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT_FREE,
    RELEASE,
    WAIT_END
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/plru_ack_sync.sv
// Two-flop synchronizer for an asynchronous acknowledge, followed by a
// rising-edge detector producing a single-cycle pulse in the local domain.
module plru_ack_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/plru_req_driver.sv
// Turns accepted access records into PLRU hit/refill requests, runs the
// drive/free/release/end handshake and keeps saturating event counters.
module plru_req_driver
  import plru_req_driver_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  rec_vld,
  output logic                  rec_rdy,
  input  logic                  rec_ld,
  input  logic                  rec_hit,
  input  logic [7:0]            rec_way,
  input  logic [6:0]            rec_addr,
  output logic [DATA_WIDTH-1:0] utlb_plru_read_hit,
  output logic                  utlb_plru_read_hit_vld,
  output logic                  utlb_plru_refill_on,
  output logic                  utlb_plru_refill_vld,
  output logic                  o_drive_hit,
  output logic                  o_drive_miss,
  input  logic                  i_free_hit,
  input  logic                  i_free_miss,
  output logic                  o_freeNext_end,
  input  logic                  i_driveNext_end,
  input  logic [DATA_WIDTH-1:0] plru_iutlb_ref_num,
  output logic                  vic_vld,
  output logic [DATA_WIDTH-1:0] vic_num,
  output logic [15:0]           cnt_hit,
  output logic [15:0]           cnt_miss,
  output logic [15:0]           cnt_skip,
  output logic                  err_timeout
);

  localparam int LANE_W = $clog2(LANE_NUM);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d, lane_nxt;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  hit_q, hit_d;
  logic                  live_q;
  logic [DATA_WIDTH-1:0] read_hit_q, read_hit_d;
  logic                  read_hit_vld_q, read_hit_vld_d;
  logic                  refill_on_q, refill_on_d;
  logic                  refill_vld_q, refill_vld_d;
  logic                  vic_vld_q, vic_vld_d;
  logic [DATA_WIDTH-1:0] vic_num_q, vic_num_d;
  logic [15:0]           cnt_hit_q, cnt_hit_d;
  logic [15:0]           cnt_miss_q, cnt_miss_d;
  logic [15:0]           cnt_skip_q, cnt_skip_d;
  logic                  err_q, err_d;
  logic                  timeout;
  logic                  accept;
  logic                  free_hit_p, free_miss_p, drive_end_p;
  logic                  addr_unused;

  plru_ack_sync u_sync_free_hit (
    .clk_i(forever_cpuclk), .rst_n_i(cpurst_b), .async_i(i_free_hit), .pulse_o(free_hit_p)
  );
  plru_ack_sync u_sync_free_miss (
    .clk_i(forever_cpuclk), .rst_n_i(cpurst_b), .async_i(i_free_miss), .pulse_o(free_miss_p)
  );
  plru_ack_sync u_sync_drive_end (
    .clk_i(forever_cpuclk), .rst_n_i(cpurst_b), .async_i(i_driveNext_end), .pulse_o(drive_end_p)
  );

  // The set address travels with the record but the PLRU request does not carry it.
  assign addr_unused = ^rec_addr;

  // live_q keeps rec_rdy low while reset is held and raises it one clock after release.
  assign rec_rdy  = (state_q == IDLE) & live_q;
  assign accept   = rec_vld & rec_rdy;
  assign lane_nxt = lane_q + LANE_W'(1);

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    wait_d         = wait_q;
    hit_d          = hit_q;
    read_hit_d     = read_hit_q;
    read_hit_vld_d = read_hit_vld_q;
    refill_on_d    = refill_on_q;
    refill_vld_d   = refill_vld_q;
    vic_vld_d      = 1'b0;
    vic_num_d      = vic_num_q;
    cnt_hit_d      = cnt_hit_q;
    cnt_miss_d     = cnt_miss_q;
    cnt_skip_d     = cnt_skip_q;
    err_d          = err_q;
    timeout        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_d = lane_nxt;
          if (!rec_ld) begin
            cnt_skip_d = sat_inc16(cnt_skip_q);
          end else begin
            hit_d = rec_hit;
            if (rec_hit) begin
              read_hit_d     = DATA_WIDTH'(rec_way) << {lane_nxt, 3'b000};
              read_hit_vld_d = 1'b1;
            end else begin
              refill_on_d  = 1'b1;
              refill_vld_d = 1'b1;
            end
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        wait_d  = '0;
        state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        // Only the acknowledge matching the outstanding request type counts.
        if (hit_q ? free_hit_p : free_miss_p) begin
          if (hit_q) begin
            cnt_hit_d = sat_inc16(cnt_hit_q);
          end else begin
            cnt_miss_d = sat_inc16(cnt_miss_q);
            vic_num_d  = plru_iutlb_ref_num;
            vic_vld_d  = 1'b1;
          end
          state_d = RELEASE;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RELEASE: begin
        wait_d  = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (drive_end_p) begin
          read_hit_d     = '0;
          read_hit_vld_d = 1'b0;
          refill_on_d    = 1'b0;
          refill_vld_d   = 1'b0;
          state_d        = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      err_d          = 1'b1;
      read_hit_d     = '0;
      read_hit_vld_d = 1'b0;
      refill_on_d    = 1'b0;
      refill_vld_d   = 1'b0;
      state_d        = IDLE;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q        <= IDLE;
      lane_q         <= '0;
      wait_q         <= '0;
      hit_q          <= 1'b0;
      live_q         <= 1'b0;
      read_hit_q     <= '0;
      read_hit_vld_q <= 1'b0;
      refill_on_q    <= 1'b0;
      refill_vld_q   <= 1'b0;
      vic_vld_q      <= 1'b0;
      vic_num_q      <= '0;
      cnt_hit_q      <= '0;
      cnt_miss_q     <= '0;
      cnt_skip_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      wait_q         <= wait_d;
      hit_q          <= hit_d;
      live_q         <= 1'b1;
      read_hit_q     <= read_hit_d;
      read_hit_vld_q <= read_hit_vld_d;
      refill_on_q    <= refill_on_d;
      refill_vld_q   <= refill_vld_d;
      vic_vld_q      <= vic_vld_d;
      vic_num_q      <= vic_num_d;
      cnt_hit_q      <= cnt_hit_d;
      cnt_miss_q     <= cnt_miss_d;
      cnt_skip_q     <= cnt_skip_d;
      err_q          <= err_d;
    end
  end

  assign utlb_plru_read_hit     = read_hit_q;
  assign utlb_plru_read_hit_vld = read_hit_vld_q;
  assign utlb_plru_refill_on    = refill_on_q;
  assign utlb_plru_refill_vld   = refill_vld_q;
  assign o_drive_hit            = (state_q == DRIVE) & hit_q;
  assign o_drive_miss           = (state_q == DRIVE) & ~hit_q;
  assign o_freeNext_end         = (state_q == RELEASE);
  assign vic_vld                = vic_vld_q;
  assign vic_num                = vic_num_q;
  assign cnt_hit                = cnt_hit_q;
  assign cnt_miss               = cnt_miss_q;
  assign cnt_skip               = cnt_skip_q;
  assign err_timeout            = err_q;

endmodule

// File: tb/tb_plru_req_driver.sv
// Directed and randomized bench for plru_req_driver against a transaction-level
// model: lane = (accepted records mod 4), counters as plain integers.
module tb_plru_req_driver;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        rec_vld = 1'b0, rec_ld = 1'b0, rec_hit = 1'b0;
  logic [7:0]  rec_way = '0;
  logic [6:0]  rec_addr = '0;
  logic        rec_rdy;
  logic [31:0] read_hit;
  logic        read_hit_vld, refill_on, refill_vld;
  logic        o_drive_hit, o_drive_miss, o_freeNext_end;
  logic        i_free_hit = 1'b0, i_free_miss = 1'b0, i_driveNext_end = 1'b0;
  logic [31:0] ref_num = '0;
  logic        vic_vld;
  logic [31:0] vic_num;
  logic [15:0] cnt_hit, cnt_miss, cnt_skip;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  int acc = 0;
  int m_hit = 0, m_miss = 0, m_skip = 0;
  logic [31:0] obs_rh;

  always #5 clk = ~clk;

  plru_req_driver #(.DATA_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .rec_vld(rec_vld), .rec_rdy(rec_rdy), .rec_ld(rec_ld), .rec_hit(rec_hit),
    .rec_way(rec_way), .rec_addr(rec_addr),
    .utlb_plru_read_hit(read_hit), .utlb_plru_read_hit_vld(read_hit_vld),
    .utlb_plru_refill_on(refill_on), .utlb_plru_refill_vld(refill_vld),
    .o_drive_hit(o_drive_hit), .o_drive_miss(o_drive_miss),
    .i_free_hit(i_free_hit), .i_free_miss(i_free_miss),
    .o_freeNext_end(o_freeNext_end), .i_driveNext_end(i_driveNext_end),
    .plru_iutlb_ref_num(ref_num), .vic_vld(vic_vld), .vic_num(vic_num),
    .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_skip(cnt_skip),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters();
    chk("cnt_hit", 64'(cnt_hit), 64'(m_hit));
    chk("cnt_miss", 64'(cnt_miss), 64'(m_miss));
    chk("cnt_skip", 64'(cnt_skip), 64'(m_skip));
  endtask

  task automatic model_reset();
    acc = 0; m_hit = 0; m_miss = 0; m_skip = 0;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (rec_rdy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("rdy_wait", 64'(rec_rdy), 64'd1);
  endtask

  task automatic accept_rec(input bit ld, input bit hit, input logic [7:0] way);
    wait_rdy();
    rec_vld = 1'b1; rec_ld = ld; rec_hit = hit; rec_way = way;
    rec_addr = 7'($urandom);
    @(negedge clk);
    rec_vld = 1'b0;
    acc++;
  endtask

  task automatic do_txn(input bit ld, input bit hit, input logic [7:0] way,
                        input logic [31:0] refv, input int dly, output logic [31:0] rh);
    int n;
    logic [31:0] exp_rh;
    rh = '0;
    accept_rec(ld, hit, way);
    if (!ld) begin
      m_skip++;
      chk("skip_rdy", 64'(rec_rdy), 64'd1);
      chk("skip_nodrive", 64'({o_drive_hit, o_drive_miss}), 64'd0);
      chk("skip_cnt", 64'(cnt_skip), 64'(m_skip));
      return;
    end
    exp_rh = hit ? (32'(way) << (8 * (acc % 4))) : 32'd0;
    rh = read_hit;
    chk("drive_pulse", 64'({o_drive_hit, o_drive_miss}), hit ? 64'd2 : 64'd1);
    chk("read_hit", 64'(read_hit), 64'(exp_rh));
    chk("qualifiers", 64'({read_hit_vld, refill_on, refill_vld}), hit ? 64'd4 : 64'd3);
    @(negedge clk);
    chk("drive_once", 64'({o_drive_hit, o_drive_miss}), 64'd0);
    repeat (dly) @(negedge clk);
    ref_num = refv;
    if (hit) i_free_hit = 1'b1; else i_free_miss = 1'b1;
    n = 0;
    while (n < 20 && o_freeNext_end !== 1'b1) begin @(negedge clk); n++; end
    chk("ack_latency", 64'(n), 64'd3);
    if (hit) m_hit++; else m_miss++;
    chk("vic_vld", 64'(vic_vld), hit ? 64'd0 : 64'd1);
    if (!hit) chk("vic_num", 64'(vic_num), 64'(refv));
    chk("hold_qual", 64'({read_hit, read_hit_vld, refill_on, refill_vld}),
        64'({exp_rh, hit, !hit, !hit}));
    i_free_hit = 1'b0; i_free_miss = 1'b0; ref_num = $urandom;
    @(negedge clk);
    chk("release_once", 64'({o_freeNext_end, vic_vld}), 64'd0);
    chk_counters();
    i_driveNext_end = 1'b1;
    n = 0;
    while (n < 20 && rec_rdy !== 1'b1) begin @(negedge clk); n++; end
    chk("end_latency", 64'(n), 64'd3);
    chk("cleared", 64'({read_hit, read_hit_vld, refill_on, refill_vld}), 64'd0);
    i_driveNext_end = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); cpurst_b = 1'b0;
    repeat (2) @(negedge clk);
    cpurst_b = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rdy_after_rst", 64'(rec_rdy), 64'd1);
  endtask

  initial begin
    logic [31:0] seq_exp [4];
    int n;
    bit saw_rel;
    seq_exp[0] = 32'h0000_0100; seq_exp[1] = 32'h0001_0000;
    seq_exp[2] = 32'h0100_0000; seq_exp[3] = 32'h0000_0001;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(rec_rdy), 64'd0);
    chk("rst_outs", 64'({read_hit_vld, refill_on, refill_vld, o_drive_hit, o_drive_miss,
                         o_freeNext_end, vic_vld, err_timeout}), 64'd0);
    chk("rst_cnt", 64'({cnt_hit, cnt_miss, cnt_skip}), 64'd0);
    cpurst_b = 1'b1;
    @(negedge clk);
    chk("rdy_first_clk", 64'(rec_rdy), 64'd1);

    // single load hit, way 4, lane 1
    do_txn(1'b1, 1'b1, 8'h04, 32'h0, 0, obs_rh);
    chk("hit_way4", 64'(obs_rh), 64'h0000_0400);
    chk("cnt_hit_1", 64'(cnt_hit), 64'd1);

    // lane walk from a fresh reset
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b1, 8'h01, 32'h0, 0, obs_rh);
      chk("lane_seq", 64'(obs_rh), 64'(seq_exp[i]));
    end

    // load miss with victim capture
    do_txn(1'b1, 1'b0, 8'h00, 32'h0000_8000, 1, obs_rh);
    chk("vic_num_8000", 64'(vic_num), 64'h0000_8000);
    chk("cnt_miss_1", 64'(cnt_miss), 64'd1);

    // store record skipped, next load on the advanced lane
    do_txn(1'b0, 1'b0, 8'h00, 32'h0, 0, obs_rh);
    do_txn(1'b1, 1'b1, 8'h80, 32'h0, 0, obs_rh);
    chk("lane_after_skip", 64'(obs_rh), 64'h8000_0000);

    // timeout with a stray wrong-type acknowledge
    accept_rec(1'b1, 1'b1, 8'h02);
    @(negedge clk);
    n = 0; saw_rel = 1'b0;
    while (err_timeout !== 1'b1 && n < 200) begin
      if (n == 2) i_free_miss = 1'b1;
      if (n == 8) i_free_miss = 1'b0;
      if (o_freeNext_end === 1'b1) saw_rel = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("stray_ignored", 64'(saw_rel), 64'd0);
    chk("timeout_idle", 64'({rec_rdy, read_hit_vld, err_timeout}), 64'd5);
    chk("timeout_clr", 64'(read_hit), 64'd0);
    chk_counters();

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      bit ld, hit;
      logic [7:0] way;
      ld  = ($urandom_range(0, 3) != 0);
      hit = 1'($urandom);
      way = 8'(1 << $urandom_range(0, 7));
      do_txn(ld, hit, way, $urandom, $urandom_range(0, 5), obs_rh);
    end
    chk_counters();
    chk("err_sticky", 64'(err_timeout), 64'd1);

    // reset while waiting for the free acknowledge
    accept_rec(1'b1, 1'b1, 8'h10);
    repeat (2) @(negedge clk);
    #2 cpurst_b = 1'b0;
    #1;
    model_reset();
    chk("midrst_outs", 64'({rec_rdy, read_hit_vld, refill_on, refill_vld, o_drive_hit,
                            o_drive_miss, o_freeNext_end, vic_vld, err_timeout}), 64'd0);
    chk("midrst_vals", 64'({read_hit, vic_num}), 64'd0);
    chk_counters();
    @(negedge clk); cpurst_b = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 64'(rec_rdy), 64'd1);
    do_txn(1'b1, 1'b1, 8'h01, 32'h0, 0, obs_rh);
    chk("lane_restart", 64'(obs_rh), 64'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
